// File: rtl/mmio_gpio_intc_pkg.sv
// Shared SoC constants for the GPIO/interrupt block: register word offsets and POL encoding.
// Latency: n/a (constants and a pure helper function).
// Backpressure: n/a.
package mmio_gpio_intc_pkg;

    // Word offsets (byte address bits [4:2]) used by the block, the address decoder and software.
    localparam logic [2:0] GPIO_REG_IN      = 3'd0;
    localparam logic [2:0] GPIO_REG_OUT     = 3'd1;
    localparam logic [2:0] GPIO_REG_PEND    = 3'd2;
    localparam logic [2:0] GPIO_REG_MASK    = 3'd3;
    localparam logic [2:0] GPIO_REG_POL     = 3'd4;
    localparam logic [2:0] GPIO_REG_BOTH    = 3'd5;
    localparam logic [2:0] GPIO_REG_OUT_TGL = 3'd6;
    localparam logic [2:0] GPIO_REG_RSVD    = 3'd7;

    // Per-channel edge polarity select.
    localparam logic GPIO_POL_RISE = 1'b0;
    localparam logic GPIO_POL_FALL = 1'b1;

    // True when a debounced transition to new_lvl counts as an interrupt event.
    function automatic logic edge_qualifies(input logic new_lvl, input logic pol, input logic both);
        return both | (new_lvl ? (pol == GPIO_POL_RISE) : (pol == GPIO_POL_FALL));
    endfunction

endpackage

// File: rtl/gpio_debounce_ch.sv
// One input channel: 2-flop synchroniser, stability counter, debounced level and edge event.
// Latency: a level held from edge t0 appears on lvl_o at edge t0+DB_CYCLES+1; evt_o is combinational with that edge.
// Backpressure: none; the channel free-runs every cycle.
module gpio_debounce_ch
    import mmio_gpio_intc_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin_i,
    input  logic pol_i,
    input  logic both_i,
    output logic lvl_o,
    output logic evt_o
);

    localparam int             CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1_q, s2_q, db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    // Accept the synchronised level once it has differed from the debounced one long enough.
    always_comb begin
        accept = (s2_q != db_q) && (cnt_q == CNT_LAST);
        db_d   = accept ? s2_q : db_q;
        cnt_d  = ((s2_q == db_q) || accept) ? '0 : cnt_q + CW'(1);
        evt_o  = accept && edge_qualifies(s2_q, pol_i, both_i);
        lvl_o  = db_q;
    end

    // Synchroniser, debounced level and stability counter; reset drops any partial count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= pin_i;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_gpio_intc.sv
// GPIO block: debounced inputs with edge-latched pending interrupts, output register, MMIO register file.
// Latency: writes take effect on the next edge; rdata is combinational; irq follows PEND&MASK by one edge.
// Backpressure: none; every selected access completes in a single cycle.
module mmio_gpio_intc
    import mmio_gpio_intc_pkg::*;
#(
    parameter int N_IN      = 16,
    parameter int N_OUT     = 16,
    parameter int DB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sel,
    input  logic              we,
    input  logic [2:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [N_IN-1:0]   pins_in,
    output logic [N_OUT-1:0]  pins_out,
    output logic              irq
);

    logic [N_IN-1:0]  in_db, evt;
    logic [N_IN-1:0]  pend_q, pend_d, pend_clr;
    logic [N_IN-1:0]  mask_q, mask_d, pol_q, pol_d, both_q, both_d;
    logic [N_OUT-1:0] out_q, out_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             unused_wdata;

    // Upper wdata bits are don't-care when the channel counts are below 32.
    assign unused_wdata = ^wdata;
    assign wr_en        = sel & we;

    for (genvar g = 0; g < N_IN; g++) begin : g_ch
        gpio_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
            .clk    (clk),
            .resetn (resetn),
            .pin_i  (pins_in[g]),
            .pol_i  (pol_q[g]),
            .both_i (both_q[g]),
            .lvl_o  (in_db[g]),
            .evt_o  (evt[g])
        );
    end

    // Register-file write decode; a new event on a bit beats a same-cycle W1C of it.
    always_comb begin
        out_d    = out_q;
        mask_d   = mask_q;
        pol_d    = pol_q;
        both_d   = both_q;
        pend_clr = '0;
        if (wr_en) begin
            case (addr)
                GPIO_REG_OUT:     out_d    = wdata[N_OUT-1:0];
                GPIO_REG_OUT_TGL: out_d    = out_q ^ wdata[N_OUT-1:0];
                GPIO_REG_PEND:    pend_clr = wdata[N_IN-1:0];
                GPIO_REG_MASK:    mask_d   = wdata[N_IN-1:0];
                GPIO_REG_POL:     pol_d    = wdata[N_IN-1:0];
                GPIO_REG_BOTH:    both_d   = wdata[N_IN-1:0];
                default:          ;
            endcase
        end
        pend_d = (pend_q & ~pend_clr) | evt;
        irq_d  = |(pend_q & mask_q);
    end

    // Architectural registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q  <= '0;
            pend_q <= '0;
            mask_q <= '0;
            pol_q  <= '0;
            both_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            pend_q <= pend_d;
            mask_q <= mask_d;
            pol_q  <= pol_d;
            both_q <= both_d;
            irq_q  <= irq_d;
        end
    end

    // Combinational read mux; nothing is driven when the block is not selected.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                GPIO_REG_IN:   rdata = 32'(in_db);
                GPIO_REG_OUT:  rdata = 32'(out_q);
                GPIO_REG_PEND: rdata = 32'(pend_q);
                GPIO_REG_MASK: rdata = 32'(mask_q);
                GPIO_REG_POL:  rdata = 32'(pol_q);
                GPIO_REG_BOTH: rdata = 32'(both_q);
                default:       rdata = '0;
            endcase
        end
    end

    assign pins_out = out_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_mmio_gpio_intc.sv
// Bench for mmio_gpio_intc: directed scenarios plus random traffic against a behavioural model.
// Latency: model updated at every rising edge, outputs sampled 1ns later.
// Backpressure: n/a.
module tb_mmio_gpio_intc;
    import mmio_gpio_intc_pkg::*;

    localparam int N_IN  = 16;
    localparam int N_OUT = 16;
    localparam int DB    = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              sel = 1'b0, we = 1'b0;
    logic [2:0]        addr = '0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic [N_IN-1:0]   pins = '0;
    logic [N_OUT-1:0]  pins_out;
    logic              irq;

    int n_chk = 0;
    int n_bad = 0;

    // Behavioural model state.
    logic [N_IN-1:0]  m_in, m_pend, m_mask, m_pol, m_both;
    logic [N_OUT-1:0] m_out;
    logic             m_irq;
    logic [N_IN-1:0]  hist[$];   // pin vectors sampled at each edge, newest at the back

    mmio_gpio_intc #(.N_IN(N_IN), .N_OUT(N_OUT), .DB_CYCLES(DB)) dut (
        .clk(clk), .resetn(resetn), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .pins_in(pins), .pins_out(pins_out), .irq(irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_in = '0; m_pend = '0; m_mask = '0; m_pol = '0; m_both = '0; m_out = '0; m_irq = 1'b0;
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_back('0);
    endtask

    // A channel flips when the pin was seen at the opposite level on DB consecutive
    // synchronised samples; the synchroniser delays each sample by two edges.
    task automatic model_edge();
        logic [N_IN-1:0] evt, clr;
        logic            all_diff, new_lvl;
        int              n;
        m_irq = |(m_pend & m_mask);
        hist.push_back(pins);
        n   = hist.size();
        evt = '0;
        for (int c = 0; c < N_IN; c++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++)
                if (hist[n-3-j][c] == m_in[c]) all_diff = 1'b0;
            if (all_diff) begin
                new_lvl = ~m_in[c];
                m_in[c] = new_lvl;
                if (m_both[c] || (new_lvl && !m_pol[c]) || (!new_lvl && m_pol[c])) evt[c] = 1'b1;
            end
        end
        while (hist.size() > DB + 2) void'(hist.pop_front());
        clr = '0;
        if (sel && we) begin
            case (addr)
                GPIO_REG_OUT:     m_out  = wdata[N_OUT-1:0];
                GPIO_REG_OUT_TGL: m_out  = m_out ^ wdata[N_OUT-1:0];
                GPIO_REG_PEND:    clr    = wdata[N_IN-1:0];
                GPIO_REG_MASK:    m_mask = wdata[N_IN-1:0];
                GPIO_REG_POL:     m_pol  = wdata[N_IN-1:0];
                GPIO_REG_BOTH:    m_both = wdata[N_IN-1:0];
                default:          ;
            endcase
        end
        m_pend = (m_pend & ~clr) | evt;
    endtask

    function automatic logic [31:0] mread(input logic [2:0] a);
        case (a)
            GPIO_REG_IN:   return 32'(m_in);
            GPIO_REG_OUT:  return 32'(m_out);
            GPIO_REG_PEND: return 32'(m_pend);
            GPIO_REG_MASK: return 32'(m_mask);
            GPIO_REG_POL:  return 32'(m_pol);
            GPIO_REG_BOTH: return 32'(m_both);
            default:       return 32'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        sel = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic model_chk_all(input string tag);
        for (int a = 0; a < 8; a++) rd_chk($sformatf("%s_r%0d", tag, a), 3'(a), mread(3'(a)));
        chk({tag, "_irq"}, 32'(irq), 32'(m_irq));
        chk({tag, "_pins_out"}, 32'(pins_out), 32'(m_out));
    endtask

    initial begin
        logic [31:0] d;
        int          r;
        model_reset();

        // Reset state.
        #15;
        for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_r%0d", a), 3'(a), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_pins_out", 32'(pins_out), 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        tick();

        // Rising edge on ch0 with MASK=1: IN/PEND at t0+5, irq at t0+6.
        bus_write(GPIO_REG_MASK, 32'h1);
        pins[0] = 1'b1;
        repeat (5) tick();
        rd_chk("lat_in_t4", GPIO_REG_IN, 32'h0);
        rd_chk("lat_pend_t4", GPIO_REG_PEND, 32'h0);
        tick();
        rd_chk("lat_in_t5", GPIO_REG_IN, 32'h1);
        rd_chk("lat_pend_t5", GPIO_REG_PEND, 32'h1);
        chk("lat_irq_t5", 32'(irq), 32'h0);
        tick();
        chk("lat_irq_t6", 32'(irq), 32'h1);

        // Three-cycle glitch on ch3 is filtered.
        pins[3] = 1'b1;
        repeat (3) tick();
        pins[3] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            rd_chk("glitch_in", GPIO_REG_IN, 32'h1);
            rd_chk("glitch_pend", GPIO_REG_PEND, 32'h1);
            chk("glitch_irq", 32'(irq), 32'h1);
        end

        // Falling polarity then both-edge mode on ch2.
        bus_write(GPIO_REG_POL, 32'h4);
        pins[2] = 1'b1;
        repeat (8) tick();
        rd_chk("pol_rise_in", GPIO_REG_IN, 32'h5);
        rd_chk("pol_rise_pend", GPIO_REG_PEND, 32'h1);
        pins[2] = 1'b0;
        repeat (8) tick();
        rd_chk("pol_fall_pend", GPIO_REG_PEND, 32'h5);
        bus_write(GPIO_REG_PEND, 32'h4);
        bus_write(GPIO_REG_BOTH, 32'h4);
        rd_chk("both_cfg_no_pend", GPIO_REG_PEND, 32'h1);
        pins[2] = 1'b1;
        repeat (8) tick();
        rd_chk("both_rise_pend", GPIO_REG_PEND, 32'h5);
        bus_write(GPIO_REG_PEND, 32'h4);
        pins[2] = 1'b0;
        repeat (8) tick();
        rd_chk("both_fall_pend", GPIO_REG_PEND, 32'h5);

        // W1C colliding with a new event on ch5: set wins.
        bus_write(GPIO_REG_BOTH, 32'h24);
        bus_write(GPIO_REG_MASK, 32'h20);
        bus_write(GPIO_REG_PEND, 32'hFFFF);
        pins[5] = 1'b1;
        repeat (8) tick();
        rd_chk("w1c_pre_pend", GPIO_REG_PEND, 32'h20);
        chk("w1c_pre_irq", 32'(irq), 32'h1);
        pins[5] = 1'b0;
        repeat (5) tick();
        bus_write(GPIO_REG_PEND, 32'h20);
        rd_chk("w1c_collide_pend", GPIO_REG_PEND, 32'h20);
        bus_write(GPIO_REG_PEND, 32'h20);
        rd_chk("w1c_alone_pend", GPIO_REG_PEND, 32'h0);
        chk("w1c_irq_hold", 32'(irq), 32'h1);
        tick();
        chk("w1c_irq_fall", 32'(irq), 32'h0);

        // Output register, toggle, read-only and unmapped offsets.
        bus_write(GPIO_REG_OUT, 32'h00FF);
        bus_write(GPIO_REG_OUT_TGL, 32'h0F0F);
        chk("tgl_pins_out", 32'(pins_out), 32'h0FF0);
        rd_chk("tgl_out_rd", GPIO_REG_OUT, 32'h0FF0);
        rd_chk("rsvd_rd", GPIO_REG_RSVD, 32'h0);
        rd_chk("tgl_rd", GPIO_REG_OUT_TGL, 32'h0);
        bus_write(GPIO_REG_IN, 32'hFFFF_FFFF);
        rd_chk("ro_in", GPIO_REG_IN, 32'h1);
        bus_write(GPIO_REG_RSVD, 32'hFFFF_FFFF);
        rd_chk("rsvd_wr", GPIO_REG_RSVD, 32'h0);
        bus_write(GPIO_REG_OUT, 32'hFFFF_FFFF);
        rd_chk("out_width", GPIO_REG_OUT, 32'h0000_FFFF);
        bus_write(GPIO_REG_MASK, 32'hFFFF_FFFF);
        rd_chk("mask_width", GPIO_REG_MASK, 32'h0000_FFFF);
        sel = 1'b0; addr = GPIO_REG_OUT; #1;
        chk("unsel_rdata", rdata, 32'h0);
        model_chk_all("dir");

        // Reset mid-debounce with PEND[0]=1, then pins held high across release.
        bus_write(GPIO_REG_PEND, 32'hFFFF);
        pins[0] = 1'b0;
        repeat (8) tick();
        pins[0] = 1'b1;
        repeat (8) tick();
        rd_chk("prerst_pend", GPIO_REG_PEND, 32'h1);
        chk("prerst_irq", 32'(irq), 32'h1);
        pins[1] = 1'b1;
        repeat (3) tick();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        for (int a = 0; a < 8; a++) rd_chk($sformatf("midrst_r%0d", a), 3'(a), 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        chk("midrst_pins_out", 32'(pins_out), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (5) tick();
        rd_chk("rel_pend_t4", GPIO_REG_PEND, 32'h0);
        tick();
        rd_chk("rel_pend_t5", GPIO_REG_PEND, 32'h3);
        rd_chk("rel_in_t5", GPIO_REG_IN, 32'h3);
        model_chk_all("rel");

        // Random pin activity and register traffic against the model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, N_IN - 1);
                pins[r] = ~pins[r];
            end
            if ($urandom_range(0, 3) == 0)
                bus_write(3'($urandom_range(0, 7)), $urandom);
            else
                tick();
            chk("rnd_irq", 32'(irq), 32'(m_irq));
            chk("rnd_pins_out", 32'(pins_out), 32'(m_out));
            r = $urandom_range(0, 7);
            bus_read(3'(r), d);
            chk($sformatf("rnd_r%0d", r), d, mread(3'(r)));
        end
        model_chk_all("end");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_gpio_intc.md
MMIO_GPIO_INTC -- requirements
Module: mmio_gpio_intc

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N_IN, 16, debounced input channels (1..32); every channel can raise an interrupt.
  N_OUT, 16, output register width (1..32).
  DB_CYCLES, 4, consecutive stable cycles required to accept a new input level (>=1).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk, in, 1, single clock; all state on rising edge.
  resetn, in, 1, asynchronous active-low reset.
  sel, in, 1, block selected by SoC address decode.
  we, in, 1, write strobe, effective only when sel=1.
  addr, in, 3, word offset (byte address bits [4:2]).
  wdata, in, 32, write data.
  rdata, out, 32, read data, combinational from addr.
  pins_in, in, N_IN, raw asynchronous inputs (switches, interrupt button).
  pins_out, out, N_OUT, output register (LEDs).
  irq, out, 1, registered level interrupt to the core.

Function
REQ-003 Register map by addr SHALL be: 0 IN (RO), 1 OUT (RW), 2 PEND (read; write-1-to-clear), 3 MASK (RW), 4 POL (RW; 0 rising, 1 falling), 5 BOTH (RW; 1 = both edges, overrides POL), 6 OUT_TGL (WO; XOR into OUT), 7 reads 0.
REQ-004 Bits at or above N_IN (or N_OUT for OUT) SHALL read 0; writes to RO or unmapped offsets SHALL be ignored.
REQ-005 rdata SHALL be combinational and valid whenever sel=1; rdata SHALL be 0 when sel=0.
REQ-006 Each pins_in bit SHALL pass through a two-flop synchroniser (s1, s2).
REQ-007 Each channel SHALL have a counter of width $clog2(DB_CYCLES+1); the counter increments while s2!=in_db and clears to 0 when s2==in_db.
REQ-008 When s2!=in_db and counter==DB_CYCLES-1, in_db SHALL take s2 on that edge and the counter SHALL clear; a level held on pins_in from edge t0 is reflected in IN at edge t0+DB_CYCLES+1.
REQ-009 A pulse shorter than DB_CYCLES synchronised cycles SHALL NOT change in_db or PEND.
REQ-010 A qualifying in_db transition (per POL/BOTH) SHALL set the channel's PEND bit on the same edge in_db updates, regardless of MASK.
REQ-011 A PEND W1C write and a new qualifying event on the same bit in the same cycle SHALL leave the bit set (set wins).
REQ-012 irq SHALL be registered: irq <= |(PEND & MASK); irq therefore rises one edge after PEND sets and falls one edge after the last unmasked pending bit clears or is masked.
REQ-013 OUT_TGL write SHALL be OUT <= OUT ^ wdata[N_OUT-1:0]; pins_out SHALL equal OUT directly.
REQ-014 Changing POL/BOTH SHALL NOT itself set PEND; only subsequent in_db transitions are qualified.

Reset
REQ-015 While resetn=0, asynchronously: s1, s2, in_db, counters, OUT, PEND, MASK, POL, BOTH and irq SHALL all be 0.
REQ-016 An input held high across reset release SHALL be accepted as a rising transition after DB_CYCLES+1 edges and SHALL set PEND if POL=0 or BOTH=1.
REQ-017 Reset asserted mid-debounce SHALL discard the partial count; no PEND bit survives reset.

Structure
REQ-018 Register offsets (0..7) and the POL encoding SHALL be constants in the shared SoC package, also used by the address decoder and the software header.
REQ-019 Per-channel synchroniser, debounce counter and edge qualifier SHALL be one sub-module, gpio_debounce_ch, instantiated N_IN times via generate; register file, PEND and irq logic stay in the top.

Verification
REQ-020 DB_CYCLES=4: pins_in[0] 0->1 at edge t0, MASK=1 -> IN[0]=1 and PEND[0]=1 at t0+5, irq=1 at t0+6.
REQ-021 3-cycle glitch on pins_in[3] -> IN, PEND and irq unchanged for 20 cycles.
REQ-022 POL[2]=1; pin 2 rises then falls -> PEND[2] stays 0 after the rise, sets after the fall; BOTH[2]=1 -> sets on both.
REQ-023 PEND[5]=1, W1C 0x20 in the same cycle as a new event on ch5 -> PEND[5] remains 1; W1C alone -> 0, irq low one edge later.
REQ-024 OUT=0x00FF, write OUT_TGL=0x0F0F -> pins_out=0x0FF0; read addr 7 -> 0; write IN -> IN unchanged.
REQ-025 resetn pulsed low mid-debounce with MASK=0xFFFF, PEND=0x0001 -> all registers 0 immediately; pin held high -> PEND re-sets DB_CYCLES+1 edges after release.
